// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the adder-sharing arbiter: FSM state encoding and
// default sizing.
package adder_share_pkg;

    localparam int DEF_W    = 16;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request, shared-adder and response signals of the arbiter. The slave modport
// is the arbiter; the master modport is the environment around it.
interface adder_share_arbiter_if
    import adder_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
) ();

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_cin;
    logic [W-1:0]      add_sum;
    logic              add_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;

    modport master (
        output req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
        input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
        output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

endinterface

// File: rtl/adder_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr (wrapping at
// NREQ-1), returned as a one-hot grant plus its index.
module rr_pick #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [IDW-1:0] w_cand;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves
        // one unassigned; otherwise synthesis would infer latches.
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IDW'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer that feeds one external W-bit adder from registered
// operands and returns the tagged, registered result.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
) (
    input logic                  clk,
    input logic                  rst,
    adder_share_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NREQ);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [IDW-1:0]  r_rsp_id;
    logic [W-1:0]    r_op_a;
    logic [W-1:0]    r_op_b;
    logic            r_op_cin;
    logic [W-1:0]    r_rsp_sum;
    logic            r_rsp_cout;
    logic [NREQ-1:0] w_gnt;
    logic [NREQ-1:0] w_req_ready;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic            w_accept;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_ff @(posedge clk) begin
        // NOTE: clocked state is written with <= so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Grants are suppressed while rst is high so no requester sees a false accept.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_req_ready = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any && !rst) begin
                    w_accept    = 1'b1;
                    w_req_ready = w_gnt;
                    w_state_nxt = ST_ADD;
                end
            end
            ST_ADD:  w_state_nxt = ST_RESP;
            ST_RESP: if (bus.rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= IDW'(NREQ - 1);
            r_id       <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_cin   <= 1'b0;
            r_rsp_id   <= '0;
            r_rsp_sum  <= '0;
            r_rsp_cout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_a   <= bus.req_a[int'(w_idx) * W +: W];
                r_op_b   <= bus.req_b[int'(w_idx) * W +: W];
                r_op_cin <= bus.req_cin[w_idx];
                r_id     <= w_idx;
                r_ptr    <= w_idx;
            end
            if (r_state == ST_ADD) begin
                r_rsp_sum  <= bus.add_sum;
                r_rsp_cout <= bus.add_cout;
                r_rsp_id   <= r_id;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.add_a     = r_op_a;
    assign bus.add_b     = r_op_b;
    assign bus.add_cin   = r_op_cin;
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_cout  = r_rsp_cout;

endmodule
